// File: rtl/seg7_capture.sv
// Recovers four hex digits from a multiplexed active-low seven-segment bus.
// Optional SEG7_ERR_COUNT_EN adds a saturating pattern-error counter (err_count, err_clr).
module seg7_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1000,
  parameter int CW            = 10
) (
  input  logic        CLK1,
  input  logic        arst_n,
  input  logic [0:6]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        pattern_err
`ifdef SEG7_ERR_COUNT_EN
  ,
  input  logic        err_clr,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 2);

  logic [10:0]   sync_q [SYNC_STAGES];
  logic [10:0]   sample_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q;
  logic [15:0]   digits_q;
  logic [3:0]    digit_valid_q;
  logic [3:0]    mask_q;
  logic          frame_valid_q;
  logic          pattern_err_q;

  logic [10:0] smp_now;
  logic        changed;
  logic [3:0]  upd_pos;
  logic [4:0]  dec;
  logic        is_blank;
  logic [3:0]  mask_set;
  logic [3:0]  mask_base;

  // Bit a is the MSB of the 7-bit pattern, matching the a..g table order.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: return {1'b1, 4'h0};
      7'b1001111: return {1'b1, 4'h1};
      7'b0010010: return {1'b1, 4'h2};
      7'b0000110: return {1'b1, 4'h3};
      7'b1001100: return {1'b1, 4'h4};
      7'b0100100: return {1'b1, 4'h5};
      7'b0100000: return {1'b1, 4'h6};
      7'b0001111: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0000100: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b1100000: return {1'b1, 4'hB};
      7'b0110001: return {1'b1, 4'hC};
      7'b1000010: return {1'b1, 4'hD};
      7'b0110000: return {1'b1, 4'hE};
      7'b0111000: return {1'b1, 4'hF};
      default:    return 5'b0;
    endcase
  endfunction

  always_ff @(posedge CLK1 or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {an, seg};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    smp_now  = sync_q[SYNC_STAGES-1];
    changed  = (smp_now != sample_q);
    dec      = decode(sample_q[6:0]);
    is_blank = (sample_q[6:0] == 7'b1111111);
    case (sample_q[10:7])
      4'b1110: upd_pos = 4'b0001;
      4'b1101: upd_pos = 4'b0010;
      4'b1011: upd_pos = 4'b0100;
      4'b0111: upd_pos = 4'b1000;
      4'b0000: upd_pos = 4'b1111;
      default: upd_pos = 4'b0000;
    endcase
    mask_set  = ((state_q == CAPTURE) && (dec[4] || is_blank)) ? upd_pos : 4'b0000;
    mask_base = (mask_q == 4'hF) ? 4'h0 : mask_q;
  end

  always_ff @(posedge CLK1 or negedge arst_n) begin
    if (!arst_n) begin
      sample_q      <= '1;
      cnt_q         <= '0;
      state_q       <= IDLE;
      digits_q      <= '0;
      digit_valid_q <= '0;
      mask_q        <= '0;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      sample_q      <= smp_now;
      pattern_err_q <= 1'b0;
      frame_valid_q <= (mask_q == 4'hF);
      mask_q        <= mask_base | mask_set;
      case (state_q)
        IDLE: begin
          if (changed || smp_now[10:7] == 4'hF) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          for (int i = 0; i < 4; i++) begin
            if (upd_pos[i] && dec[4]) begin
              digits_q[4*i +: 4] <= dec[3:0];
              digit_valid_q[i]   <= 1'b1;
            end else if (upd_pos[i] && is_blank) begin
              digit_valid_q[i]   <= 1'b0;
            end
          end
          if (upd_pos != 4'b0000 && !dec[4] && !is_blank) pattern_err_q <= 1'b1;
          // A change arriving during the capture cycle starts a fresh window.
          cnt_q   <= '0;
          state_q <= changed ? IDLE : HOLD;
        end
        HOLD: begin
          if (changed) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign digits      = digits_q;
  assign digit_valid = digit_valid_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge CLK1 or negedge arst_n) begin
    if (!arst_n)                                    err_count_q <= '0;
    else if (err_clr)                               err_count_q <= '0;
    else if (pattern_err_q && err_count_q != 8'hFF) err_count_q <= err_count_q + 1'b1;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_seg7_capture;

  logic        clk;
  logic        arst_n;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        pattern_err;
`ifdef SEG7_ERR_COUNT_EN
  logic        err_clr;
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  int err_cnt = 0;

  seg7_capture #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CW           (10)
  ) dut (
    .CLK1       (clk),
    .arst_n     (arst_n),
    .seg        (seg),
    .an         (an),
    .digits     (digits),
    .digit_valid(digit_valid),
    .frame_valid(frame_valid),
    .pattern_err(pattern_err)
`ifdef SEG7_ERR_COUNT_EN
    ,
    .err_clr    (err_clr),
    .err_count  (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) frame_cnt++;
    if (pattern_err === 1'b1) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int f0;
    int e0;
    bit saw8;
    logic [6:0] bad_a;
    logic [6:0] bad_b;
    bad_a = 7'b1010101;
    bad_b = 7'b0101010;
    arst_n = 1'b0;
    drive(4'b1111, 7'b1111111);
`ifdef SEG7_ERR_COUNT_EN
    err_clr = 1'b0;
`endif
    tick(3);
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_frame", 32'(frame_valid), 32'h0);
    check("rst_perr", 32'(pattern_err), 32'h0);
    arst_n = 1'b1;
    tick(3);

    // Single digit 2 on the rightmost position
    drive(4'b1110, 7'b0010010);
    tick(6);
    check("t1_latency_pre", 32'(digit_valid), 32'h0);
    tick(1);
    check("t1_digits", 32'(digits), 32'h0002);
    check("t1_valid", 32'(digit_valid), 32'h1);
    tick(3);
    check("t1_no_frame", 32'(frame_cnt), 32'd0);

    // Scan 1,2,3,4 across the four positions
    f0 = frame_cnt;
    drive(4'b1110, 7'b1001111); tick(8);
    drive(4'b1101, 7'b0010010); tick(8);
    drive(4'b1011, 7'b0000110); tick(8);
    drive(4'b0111, 7'b1001100); tick(8);
    check("t2_frame_pulse", 32'(frame_valid), 32'h1);
    check("t2_digits", 32'(digits), 32'h4321);
    check("t2_valid", 32'(digit_valid), 32'hF);
    tick(1);
    check("t2_frame_drop", 32'(frame_valid), 32'h0);
    check("t2_frame_count", 32'(frame_cnt - f0), 32'd1);

    // All-digit mode
    f0 = frame_cnt;
    drive(4'b0000, 7'b0001000);
    tick(7);
    check("t3_digits", 32'(digits), 32'hAAAA);
    tick(13);
    check("t3_frame_count", 32'(frame_cnt - f0), 32'd1);

    // Glitch inside a stable 3
    drive(4'b1110, 7'b0000110);
    tick(10);
    check("t4_digits3", 32'(digits), 32'hAAA3);
    drive(4'b1110, 7'b0000000);
    tick(1);
    drive(4'b1110, 7'b0000110);
    saw8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (digits[3:0] == 4'h8) saw8 = 1'b1;
    end
    check("t4_glitch_captured", 32'(saw8), 32'h0);
    check("t4_digits_after", 32'(digits), 32'hAAA3);

    // Undecodable pattern
    e0 = err_cnt;
    drive(4'b1110, bad_a);
    tick(6);
    check("t4_perr_early", 32'(pattern_err), 32'h0);
    tick(1);
    check("t4_perr_pulse", 32'(pattern_err), 32'h1);
    tick(1);
    check("t4_perr_drop", 32'(pattern_err), 32'h0);
    tick(10);
    check("t4_perr_count", 32'(err_cnt - e0), 32'd1);
    check("t4_perr_digits", 32'(digits), 32'hAAA3);
    check("t4_perr_valid", 32'(digit_valid), 32'hF);
`ifdef SEG7_ERR_COUNT_EN
    check("t4_err_count", 32'(err_count), 32'd1);
`endif

    // Two anodes low, then nothing lit, then blank
    e0 = err_cnt;
    f0 = frame_cnt;
    drive(4'b1100, 7'b0000001);
    tick(20);
    check("t5_two_an_digits", 32'(digits), 32'hAAA3);
    check("t5_two_an_perr", 32'(err_cnt - e0), 32'd0);
    drive(4'b1111, 7'b0000000);
    tick(20);
    check("t5_off_digits", 32'(digits), 32'hAAA3);
    check("t5_off_valid", 32'(digit_valid), 32'hF);
    drive(4'b1101, 7'b1111111);
    tick(10);
    check("t5_blank_valid", 32'(digit_valid), 32'hD);
    check("t5_blank_digits", 32'(digits), 32'hAAA3);
    check("t5_no_frame", 32'(frame_cnt - f0), 32'd0);

    // Reset mid-window
    drive(4'b1011, 7'b0100100);
    tick(3);
    arst_n = 1'b0;
    #1;
    check("t6_async_digits", 32'(digits), 32'h0);
    check("t6_async_valid", 32'(digit_valid), 32'h0);
    tick(1);
    arst_n = 1'b1;
    tick(6);
    check("t6_no_early_cap", 32'(digit_valid), 32'h0);
    tick(4);
    check("t6_digits", 32'(digits), 32'h0500);
    check("t6_valid", 32'(digit_valid), 32'h4);
    check("t6_frame", 32'(frame_valid), 32'h0);

`ifdef SEG7_ERR_COUNT_EN
    check("t7_err_rst", 32'(err_count), 32'd0);
    for (int i = 0; i < 300; i++) begin
      drive(4'b1110, (i % 2 == 0) ? bad_a : bad_b);
      tick(8);
    end
    tick(2);
    check("t7_err_sat", 32'(err_count), 32'd255);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t7_err_clr", 32'(err_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
